// File: rtl/as_layer_ctrl.sv
// rtl/as_layer_ctrl.sv - per-layer launch controller for the upsample/route address sequencer
module as_layer_ctrl #(
    parameter int W_SIZE    = 9,
    parameter int W_CHANNEL = 10,
    parameter int FM_AW     = 17
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_layer_start,
    input  logic                        i_layer_mode,
    input  logic [W_SIZE-1:0]           i_width,
    input  logic [W_SIZE-1:0]           i_height,
    input  logic [W_CHANNEL-1:0]        i_chn_a,
    input  logic [W_CHANNEL-1:0]        i_chn_b,
    input  logic                        i_num_src,
    input  logic [FM_AW-1:0]            i_base_a,
    input  logic [FM_AW-1:0]            i_base_b,
    output logic                        o_busy,
    output logic                        o_layer_done,
    output logic                        o_err,
    output logic [W_SIZE-1:0]           q_width,
    output logic [W_SIZE-1:0]           q_height,
    output logic [W_CHANNEL-1:0]        q_channel,
    output logic [W_CHANNEL-1:0]        q_channel_out,
    output logic [W_SIZE+W_CHANNEL-1:0] q_row_stride,
    output logic                        q_as_mode,
    output logic [FM_AW-1:0]            q_route_offset,
    output logic [W_CHANNEL-1:0]        q_route_chn_offset,
    output logic                        q_as_start,
    input  logic                        o_as_done
);
    localparam int W_STRIDE = W_SIZE + W_CHANNEL;
    localparam int W_CNT    = $clog2(W_SIZE + 1);

    typedef enum logic [2:0] {IDLE, MUL, LAUNCH, WAIT, DONE} state_t;
    state_t state, state_next;

    logic                 mode_r, two_src_r, pass_r;
    logic [W_SIZE-1:0]    width_r, height_r, mplier_r;
    logic [W_CHANNEL-1:0] chn_a_r, chn_b_r;
    logic [FM_AW-1:0]     base_a_r, base_b_r;
    logic [W_STRIDE-1:0]  acc_r, mcand_r;
    logic [W_CNT-1:0]     cnt_r;
    logic                 done_r, err_r, rej_r;

    logic [W_CHANNEL:0]   chn_sum;
    logic                 desc_bad, accept, next_pass;

    assign chn_sum  = {1'b0, i_chn_a} + {1'b0, i_chn_b};
    // chn_b only matters for a two-source route
    assign desc_bad = (i_width == '0) || (i_height == '0) || (i_chn_a == '0) ||
                      (i_layer_mode && i_num_src && ((i_chn_b == '0) || chn_sum[W_CHANNEL]));
    assign accept    = (state == IDLE) && i_layer_start && !desc_bad;
    assign next_pass = (state == WAIT) && done_r && !pass_r && two_src_r;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (cnt_r == W_CNT'(W_SIZE - 1)) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (done_r) state_next = next_pass ? MUL : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            two_src_r <= 1'b0;
            pass_r    <= 1'b0;
            width_r   <= '0;
            height_r  <= '0;
            chn_a_r   <= '0;
            chn_b_r   <= '0;
            base_a_r  <= '0;
            base_b_r  <= '0;
            acc_r     <= '0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            cnt_r     <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rej_r     <= 1'b0;
        end else begin
            state  <= state_next;
            // done is registered first, so only a done seen during WAIT counts
            done_r <= o_as_done && (state == WAIT);
            err_r  <= i_layer_start && ((state != IDLE) || desc_bad);
            rej_r  <= i_layer_start && (state == IDLE) && desc_bad;
            if ((state == IDLE) && i_layer_start) begin
                mode_r    <= i_layer_mode;
                two_src_r <= i_layer_mode && i_num_src;
                pass_r    <= 1'b0;
                width_r   <= i_width;
                height_r  <= i_height;
                chn_a_r   <= i_chn_a;
                chn_b_r   <= i_chn_b;
                base_a_r  <= i_base_a;
                base_b_r  <= i_base_b;
            end
            if (accept) begin
                acc_r    <= '0;
                mcand_r  <= {{W_SIZE{1'b0}}, i_chn_a};
                mplier_r <= i_width;
                cnt_r    <= '0;
            end else if (next_pass) begin
                pass_r   <= 1'b1;
                acc_r    <= '0;
                mcand_r  <= {{W_SIZE{1'b0}}, chn_b_r};
                mplier_r <= width_r;
                cnt_r    <= '0;
            end else if (state == MUL) begin
                if (mplier_r[0]) acc_r <= acc_r + mcand_r;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r + W_CNT'(1);
            end
        end
    end

    assign o_busy             = (state == MUL) || (state == LAUNCH) || (state == WAIT);
    assign o_layer_done       = (state == DONE) || rej_r;
    assign o_err              = err_r;
    assign q_width            = width_r;
    assign q_height           = height_r;
    assign q_channel          = pass_r ? chn_b_r : chn_a_r;
    assign q_channel_out      = two_src_r ? (chn_a_r + chn_b_r) : chn_a_r;
    assign q_row_stride       = acc_r;
    assign q_as_mode          = mode_r;
    assign q_route_offset     = pass_r ? base_b_r : base_a_r;
    assign q_route_chn_offset = pass_r ? chn_a_r : '0;
    assign q_as_start         = (state == LAUNCH);
endmodule
